// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants for the multiplexed seven-segment driver:
//                active-low hex glyph table, blank pattern, index width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs; entry for nibble n lives at [7n +: 7]
    localparam logic [16*7-1:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Width of an index register able to hold 0..n-1, never narrower than 1
    function automatic int DIGIT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational nibble to active-low 7-segment glyph lookup.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup; every nibble value has a glyph so no default is needed
    assign seg_o = HEX_SEG_TABLE[{nibble_i, 3'b000} - {3'b000, nibble_i} +: 7];

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_mux
//  Description : Time-multiplexed driver for a common-anode seven-segment
//                display. Scans the digits enabled in digit_mask, holding
//                each for TICK_DIV clocks. Optional ghost-suppression
//                dead-time at the start of each digit period is compiled in
//                with the macro SEVEN_SEG_GHOST_BLANK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 1,
    parameter int BLANK_CYCLES = 0
) (
    input  logic                             div_clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_DIGITS-1:0]            digit_mask,
    input  logic [4*NUM_DIGITS-1:0]          values,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    output logic [NUM_DIGITS-1:0]            anode,
    output logic [6:0]                       seg,
    output logic                             dp,
    output logic [DIGIT_W(NUM_DIGITS)-1:0]   digit_sel
);

    localparam int DW = DIGIT_W(NUM_DIGITS);
    localparam int PW = DIGIT_W(TICK_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

    logic [DW-1:0]             cur_q, cur_d;
    logic [PW-1:0]             pcnt_q, pcnt_d;
    logic [DW:0]               rot_sh;
    logic [2*NUM_DIGITS-1:0]   mask_dbl;
    logic [NUM_DIGITS-1:0]     mask_rot;
    logic [DW-1:0]             next_idx;
    logic                      blank;
    logic                      lit;
    logic [3:0]                cur_nibble;
    logic [6:0]                cur_glyph;

    // Rotate the mask so bit 0 is the digit just above cur, then take the
    // lowest set bit; an empty mask leaves next_idx at cur
    always_comb begin
        int idx;
        idx      = 0;
        rot_sh   = {1'b0, cur_q} + 1'b1;
        mask_dbl = {digit_mask, digit_mask};
        mask_rot = NUM_DIGITS'(mask_dbl >> rot_sh);
        next_idx = cur_q;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (mask_rot[k]) begin
                idx = int'(rot_sh) + k;
                if (idx >= NUM_DIGITS) begin
                    idx = idx - NUM_DIGITS;
                end
                next_idx = DW'(idx);
            end
        end
    end

    // Prescaler and digit advance; scanning freezes when disabled or when no
    // digit is selected at all
    always_comb begin
        cur_d  = cur_q;
        pcnt_d = pcnt_q;
        if (enable && (|digit_mask)) begin
            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                cur_d  = next_idx;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge div_clock or negedge reset) begin
        if (!reset) begin
            cur_q  <= '0;
            pcnt_q <= '0;
        end else begin
            cur_q  <= cur_d;
            pcnt_q <= pcnt_d;
        end
    end

`ifdef SEVEN_SEG_GHOST_BLANK_EN
    assign blank = (int'(pcnt_q) < BLANK_CYCLES);
`else
    assign blank = 1'b0;
`endif

    assign lit        = enable & digit_mask[cur_q] & ~blank;
    assign cur_nibble = values[{cur_q, 2'b00} +: 4];

    hex_to_seg u_hex (
        .nibble_i (cur_nibble),
        .seg_o    (cur_glyph)
    );

    // Output gating: dark unless the current digit is enabled and not blanked
    always_comb begin
        anode = '1;
        seg   = SEG_BLANK;
        dp    = 1'b1;
        if (lit) begin
            anode[cur_q] = 1'b0;
            seg          = cur_glyph;
            dp           = ~dp_in[cur_q];
        end
    end

    assign digit_sel = cur_q;

endmodule
`default_nettype wire
